// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
// It decodes ALUOp/funct into the ALU control code and resolves EX/MEM and
// MEM/WB forwarding for both source operands. It selects register or
// immediate for operand B, then registers everything onto the ALU inputs.
// Stall holds the outputs, flush inserts a bubble, and an asynchronous
// reset clears all outputs.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [REG_AW-1:0] rs_num,
    input  logic [REG_AW-1:0] rt_num,
    input  logic [REG_AW-1:0] rd_num,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [15:0]       imm16,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic              reg_write,
    input  logic              exmem_wr,
    input  logic              memwb_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] exmem_res,
    input  logic [DATA_W-1:0] memwb_res,
    output logic [DATA_W-1:0] ex_A,
    output logic [DATA_W-1:0] ex_B,
    output logic [3:0]        ex_alu_ctl,
    output logic [DATA_W-1:0] ex_store_data,
    output logic [REG_AW-1:0] ex_dest,
    output logic              ex_reg_write,
    output logic              ex_valid,
    output logic              ex_illegal
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_RTYPE = 2'b10,
        OP_ORI   = 2'b11
    } alu_op_e;

    typedef enum logic [5:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_AND = 6'b100100,
        FN_OR  = 6'b100101,
        FN_NOR = 6'b100111,
        FN_SLT = 6'b101010
    } funct_e;

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
    localparam logic [3:0] CTL_NOR = 4'b1100;

    alu_op_e           op;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] op_b;
    logic [3:0]        ctl;
    logic              illegal;
    logic [REG_AW-1:0] dest;
    logic              exmem_hit_rs;
    logic              exmem_hit_rt;
    logic              memwb_hit_rs;
    logic              memwb_hit_rt;

    assign op = alu_op_e'(alu_op);

    // Forwarding match detection; register 0 never matches.
    always_comb begin
        exmem_hit_rs = exmem_wr && (exmem_rd != '0) && (exmem_rd == rs_num);
        exmem_hit_rt = exmem_wr && (exmem_rd != '0) && (exmem_rd == rt_num);
        memwb_hit_rs = memwb_wr && (memwb_rd != '0) && (memwb_rd == rs_num);
        memwb_hit_rt = memwb_wr && (memwb_rd != '0) && (memwb_rd == rt_num);
    end

    // Operand forwarding with EX/MEM taking priority over MEM/WB.
    always_comb begin
        fwd_rs = rs_data;
        fwd_rt = rt_data;
        if (exmem_hit_rs) begin
            fwd_rs = exmem_res;
        end else if (memwb_hit_rs) begin
            fwd_rs = memwb_res;
        end
        if (exmem_hit_rt) begin
            fwd_rt = exmem_res;
        end else if (memwb_hit_rt) begin
            fwd_rt = memwb_res;
        end
    end

    // Immediate extension (zero-extend for ORI) and operand B select.
    always_comb begin
        if (op == OP_ORI) begin
            imm_ext = {{(DATA_W-16){1'b0}}, imm16};
        end else begin
            imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
        end
        op_b = alu_src ? imm_ext : fwd_rt;
        dest = reg_dst ? rd_num : rt_num;
    end

    // ALU control decode; unsupported R-type functs fall back to add.
    always_comb begin
        ctl     = CTL_ADD;
        illegal = 1'b0;
        case (op)
            OP_ADD: ctl = CTL_ADD;
            OP_SUB: ctl = CTL_SUB;
            OP_ORI: ctl = CTL_OR;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  ctl = CTL_ADD;
                    FN_SUB:  ctl = CTL_SUB;
                    FN_AND:  ctl = CTL_AND;
                    FN_OR:   ctl = CTL_OR;
                    FN_NOR:  ctl = CTL_NOR;
                    FN_SLT:  ctl = CTL_SLT;
                    default: begin
                        ctl     = CTL_ADD;
                        illegal = 1'b1;
                    end
                endcase
            end
            default: ctl = CTL_ADD;
        endcase
    end

    // Output register: flush > stall > no-valid bubble > load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_A          <= '0;
            ex_B          <= '0;
            ex_alu_ctl    <= '0;
            ex_store_data <= '0;
            ex_dest       <= '0;
            ex_reg_write  <= 1'b0;
            ex_valid      <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (flush || (!stall && !in_valid)) begin
            ex_A          <= '0;
            ex_B          <= '0;
            ex_alu_ctl    <= '0;
            ex_store_data <= '0;
            ex_dest       <= '0;
            ex_reg_write  <= 1'b0;
            ex_valid      <= 1'b0;
            ex_illegal    <= 1'b0;
        end else if (!stall) begin
            ex_A          <= fwd_rs;
            ex_B          <= op_b;
            ex_alu_ctl    <= ctl;
            ex_store_data <= fwd_rt;
            ex_dest       <= dest;
            ex_reg_write  <= reg_write;
            ex_valid      <= 1'b1;
            ex_illegal    <= illegal;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage. Stimulus computes the
// expected register contents from a reference model and queues them; a
// monitor pops one expectation after each rising edge and compares.
module tb_id_ex_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        ctl;
        logic [DATA_W-1:0] store;
        logic [REG_AW-1:0] dest;
        logic              rw;
        logic              valid;
        logic              ill;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid, stall, flush;
    logic [REG_AW-1:0] rs_num, rt_num, rd_num;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic [15:0]       imm16;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              alu_src, reg_dst, reg_write;
    logic              exmem_wr, memwb_wr;
    logic [REG_AW-1:0] exmem_rd, memwb_rd;
    logic [DATA_W-1:0] exmem_res, memwb_res;
    logic [DATA_W-1:0] ex_A, ex_B, ex_store_data;
    logic [3:0]        ex_alu_ctl;
    logic [REG_AW-1:0] ex_dest;
    logic              ex_reg_write, ex_valid, ex_illegal;

    exp_t q[$];
    exp_t model_state;
    int   errors = 0;
    int   checks = 0;

    logic [5:0] legal_funct [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
    logic [3:0] legal_ctl   [6] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd12, 4'd7};

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rs_num(rs_num), .rt_num(rt_num), .rd_num(rd_num),
        .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
        .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .reg_dst(reg_dst),
        .reg_write(reg_write), .exmem_wr(exmem_wr), .memwb_wr(memwb_wr),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_res(exmem_res), .memwb_res(memwb_res),
        .ex_A(ex_A), .ex_B(ex_B), .ex_alu_ctl(ex_alu_ctl),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest),
        .ex_reg_write(ex_reg_write), .ex_valid(ex_valid), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t dut_out();
        exp_t o;
        o.a = ex_A; o.b = ex_B; o.ctl = ex_alu_ctl; o.store = ex_store_data;
        o.dest = ex_dest; o.rw = ex_reg_write; o.valid = ex_valid; o.ill = ex_illegal;
        return o;
    endfunction

    // Reference value of one source operand after forwarding.
    function automatic logic [DATA_W-1:0] ref_src(input logic [REG_AW-1:0] num,
                                                 input logic [DATA_W-1:0] rf);
        if (num == 0) return rf;
        if (exmem_wr && exmem_rd == num) return exmem_res;
        if (memwb_wr && memwb_rd == num) return memwb_res;
        return rf;
    endfunction

    // Reference next register contents given current inputs and state.
    function automatic exp_t ref_next(input exp_t cur);
        exp_t n;
        int unsigned imm_val;
        n = '0;
        if (flush) return n;
        if (stall) return cur;
        if (!in_valid) return n;
        imm_val = imm16;
        if (alu_op != 2'b11 && imm16 >= 16'h8000) imm_val = imm_val + 32'hFFFF0000;
        n.a     = ref_src(rs_num, rs_data);
        n.store = ref_src(rt_num, rt_data);
        n.b     = alu_src ? imm_val : n.store;
        n.dest  = reg_dst ? rd_num : rt_num;
        n.rw    = reg_write;
        n.valid = 1'b1;
        case (alu_op)
            2'b00: n.ctl = 4'd2;
            2'b01: n.ctl = 4'd6;
            2'b11: n.ctl = 4'd1;
            default: begin
                n.ctl = 4'd2;
                n.ill = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    if (funct == legal_funct[i]) begin
                        n.ctl = legal_ctl[i];
                        n.ill = 1'b0;
                    end
                end
            end
        endcase
        return n;
    endfunction

    task automatic check(input string name, input exp_t act, input exp_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got A=%h B=%h ctl=%b st=%h dst=%0d rw=%b v=%b ill=%b, want A=%h B=%h ctl=%b st=%h dst=%0d rw=%b v=%b ill=%b",
                     name, act.a, act.b, act.ctl, act.store, act.dest, act.rw, act.valid, act.ill,
                     exp.a, exp.b, exp.ctl, exp.store, exp.dest, exp.rw, exp.valid, exp.ill);
        end
    endtask

    // Called at a negedge with inputs already set; queues the expectation.
    task automatic issue();
        model_state = ref_next(model_state);
        q.push_back(model_state);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        in_valid = 0; stall = 0; flush = 0;
        rs_num = 0; rt_num = 0; rd_num = 0; rs_data = 0; rt_data = 0;
        imm16 = 0; alu_op = 0; funct = 0; alu_src = 0; reg_dst = 0; reg_write = 0;
        exmem_wr = 0; memwb_wr = 0; exmem_rd = 0; memwb_rd = 0;
        exmem_res = 0; memwb_res = 0;
    endtask

    task automatic randomize_inputs(input bit allow_ctl);
        rs_num    = REG_AW'($urandom_range(0, 3));
        rt_num    = REG_AW'($urandom_range(0, 3));
        rd_num    = REG_AW'($urandom);
        rs_data   = $urandom;
        rt_data   = $urandom;
        imm16     = 16'($urandom);
        alu_op    = 2'($urandom);
        funct     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_funct[$urandom_range(0, 5)];
        alu_src   = 1'($urandom);
        reg_dst   = 1'($urandom);
        reg_write = 1'($urandom);
        exmem_wr  = 1'($urandom);
        memwb_wr  = 1'($urandom);
        exmem_rd  = REG_AW'($urandom_range(0, 3));
        memwb_rd  = REG_AW'($urandom_range(0, 3));
        exmem_res = $urandom;
        memwb_res = $urandom;
        if (allow_ctl) begin
            in_valid = ($urandom_range(0, 9) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
        end
    endtask

    // Monitor: the stage presents a new output after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset && q.size() > 0) check("pipe", dut_out(), q.pop_front());
        end
    end

    initial begin
        exp_t zero;
        zero = '0;
        model_state = '0;
        clear_inputs();
        reset = 1'b1;
        in_valid = 1; reg_write = 1; rs_data = 32'h55; alu_op = 2'b10; funct = 6'd1;
        #1;
        check("reset_state", dut_out(), zero);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();

        // Basic R-type subtract.
        in_valid = 1; alu_op = 2'b10; funct = 6'b100010;
        rs_num = 7; rs_data = 7; rt_num = 3; rt_data = 3; rd_num = 9;
        reg_dst = 1; reg_write = 1;
        issue();

        // Forwarding priority and register-0 exclusion.
        rs_num = 5; rs_data = 32'hAAAA;
        exmem_wr = 1; exmem_rd = 5; exmem_res = 32'h10;
        memwb_wr = 1; memwb_rd = 5; memwb_res = 32'h20;
        issue();
        exmem_wr = 0;
        issue();
        rs_num = 0; exmem_wr = 1; exmem_rd = 0; memwb_rd = 0;
        issue();
        exmem_wr = 0; memwb_wr = 0;

        // Immediate sign/zero extension.
        alu_op = 2'b00; alu_src = 1; imm16 = 16'hFFFC;
        issue();
        alu_op = 2'b11;
        issue();
        alu_src = 0;

        // Illegal and every legal funct.
        alu_op = 2'b10; funct = 6'b000011;
        issue();
        for (int i = 0; i < 6; i++) begin
            funct = legal_funct[i];
            issue();
        end

        // Stall for three cycles while inputs churn, then stall+flush, then no-valid.
        in_valid = 1; funct = 6'b100100;
        issue();
        for (int i = 0; i < 3; i++) begin
            randomize_inputs(1'b0);
            in_valid = 1; stall = 1; flush = 0;
            issue();
        end
        stall = 1; flush = 1;
        issue();
        stall = 0; flush = 0; in_valid = 1;
        issue();
        in_valid = 0;
        issue();

        // Asynchronous reset pulse mid-stall, between edges.
        in_valid = 1;
        issue();
        stall = 1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", dut_out(), zero);
        reset = 1'b0;
        model_state = '0;
        @(negedge clk);
        stall = 0; in_valid = 1; rs_num = 2; rs_data = 32'h1234;
        issue();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            randomize_inputs(1'b1);
            issue();
        end

        clear_inputs();
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It decodes ALUOp/funct into the 4-bit ALU control code and resolves EX/MEM and MEM/WB forwarding on both source operands. It selects register or immediate for operand B, then registers operands A/B, control and destination onto the ALU inputs. It supports stall (hold) and flush (bubble insertion) from the hazard unit and flags unsupported R-type funct codes.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- REG_AW, 5, register-number width

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  asynchronous, active-high; clears all outputs
- in_valid  in  1  decode stage presents a real instruction
- stall  in  1  hold all registered outputs
- flush  in  1  load a bubble
- rs_num, rt_num, rd_num  in  REG_AW  source and destination register numbers
- rs_data, rt_data  in  DATA_W  register-file read data
- imm16  in  16  instruction immediate
- alu_op  in  2  00 add, 01 sub, 10 R-type (funct), 11 ORI
- funct  in  6  R-type function field
- alu_src  in  1  1 = operand B from immediate
- reg_dst  in  1  1 = destination rd_num, 0 = rt_num
- reg_write  in  1  instruction writes the register file
- exmem_wr, memwb_wr  in  1  write enables of the later stages
- exmem_rd, memwb_rd  in  REG_AW  destination numbers of the later stages
- exmem_res, memwb_res  in  DATA_W  results of the later stages
- ex_A, ex_B  out  DATA_W  ALU operands
- ex_alu_ctl  out  4  ALU control code
- ex_store_data  out  DATA_W  forwarded rt value (for sw)
- ex_dest  out  REG_AW  destination register number
- ex_reg_write  out  1  write enable, qualified by valid
- ex_valid  out  1  stage holds a real instruction
- ex_illegal  out  1  unsupported funct under alu_op=10

## Operation
- Forwarding is applied independently to rs and rt. It uses EX/MEM if exmem_wr=1, exmem_rd!=0 and exmem_rd equals the source number. Otherwise it uses MEM/WB under the same conditions. Otherwise it uses register-file data. EX/MEM has priority when both match.
- Register 0 is never forwarded. Its value always comes from rs_data/rt_data.
- Immediate handling:
  - alu_op 00/01/10 sign-extends bit 15 to DATA_W.
  - alu_op 11 zero-extends.
- B operand is the extended immediate if alu_src=1, else forwarded rt. ex_store_data is always forwarded rt.
- ALU control decode:
  - alu_op 00 gives 0010; 01 gives 0110; 11 gives 0001.
  - alu_op 10 decodes funct: 100000 gives 0010, 100010 gives 0110, 100100 gives 0000, 100101 gives 0001, 100111 gives 1100, 101010 gives 0111.
  - Any other funct under alu_op 10 gives 0010 and illegal=1. illegal is 0 for all other cases.
- Destination is rd_num if reg_dst=1, else rt_num.
- Next-state priority on each rising edge:
  1. flush: bubble
  2. stall: hold
  3. in_valid=0: bubble
  4. otherwise: load the decoded and forwarded values
- A bubble sets every output to 0, including ex_valid, ex_reg_write and ex_illegal, with ex_alu_ctl=0000.
- ex_reg_write is reg_write AND load. It is never 1 while ex_valid=0.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on the outputs after edge N, for the ALU during cycle N+1.
- Forwarding and decode are combinational within the sampling cycle. Values are captured only at the edge; the outputs have no combinational path from the inputs.
- During stall, all outputs are bit-stable across any number of cycles, regardless of changes on the forwarding inputs.
- If stall and flush are asserted together, flush wins and a bubble is loaded.
- Reset:
  - Asserting reset at any time, including mid-stall, forces all outputs to 0 immediately, without waiting for a clock edge.
  - The first load occurs at the first rising edge after reset deasserts.
- Back-to-back loads are allowed every cycle. There is no internal state other than the output registers.

## Test plan
- Reset, then alu_op=10, funct=100010, rs=7/rs_data=7, rt=3/rt_data=3, rd=9, reg_dst=1, reg_write=1 → next cycle: ex_A=7, ex_B=3, ex_alu_ctl=0110, ex_dest=9, ex_valid=1, ex_reg_write=1.
- rs=5, exmem_wr=1/exmem_rd=5/exmem_res=0x10, memwb_wr=1/memwb_rd=5/memwb_res=0x20 → ex_A=0x10. Drop exmem_wr → ex_A=0x20. Set rs=0 with both stages targeting rd=0 → ex_A=rs_data.
- alu_op=00, alu_src=1, imm16=0xFFFC → ex_B=0xFFFFFFFC, ctl=0010. alu_op=11, same imm → ex_B=0x0000FFFC, ctl=0001.
- alu_op=10, funct=000011 → ex_alu_ctl=0010, ex_illegal=1. Each of the six legal functs → its listed code, ex_illegal=0.
- Load a valid instruction, then stall for 3 cycles while changing all inputs → outputs unchanged. Assert stall+flush together → bubble (all 0). Assert in_valid=0 → bubble.
- Mid-operation, pulse reset between clock edges → all outputs 0 before the next edge. Valid load resumes on the first edge after release.
